// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events, round-robin serialised onto one port.
// Two cycles from level change to evt_valid; a stalled port holds its event, and a newer event on a channel overwrites its older pending one (evt_drop).
module button_event_ctrl #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int N_BTN       = 4,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic [1:0]               evt_type,
  output logic                     evt_drop
);
  localparam int DIV   = CLK_FREQ_HZ / 1000;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAXMS = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int CW    = $clog2(MAXMS);
  localparam int BW    = $clog2(N_BTN);

  localparam logic [1:0] IDLE = 2'd0, HELD = 2'd1, RPT = 2'd2;
  localparam logic [1:0] T_PRESS = 2'b00, T_RELEASE = 2'b01, T_LONG = 2'b10, T_REPEAT = 2'b11;

  logic [PW-1:0]    pre;
  logic             tick;
  logic [N_BTN-1:0] prev;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [1:0]       st       [N_BTN];
  logic [1:0]       st_nxt   [N_BTN];
  logic [CW-1:0]    cnt      [N_BTN];
  logic [CW-1:0]    cnt_nxt  [N_BTN];
  logic [N_BTN-1:0] emit;
  logic [1:0]       emit_type[N_BTN];
  logic [N_BTN-1:0] pend_vld;
  logic [1:0]       pend_type[N_BTN];
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] drop;
  logic             free;
  logic             found;
  logic [BW-1:0]    win;
  logic [BW-1:0]    rr;
  int               idx;

  assign tick = (pre == PW'(DIV - 1));
  assign rise = btn_level & ~prev;
  assign fall = ~btn_level & prev;
  assign free = !evt_valid || evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      prev <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      prev <= btn_level;
    end
  end

  // Fall is tested first so it wins over a coincident tick.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      st_nxt[i]    = st[i];
      cnt_nxt[i]   = cnt[i];
      emit[i]      = 1'b0;
      emit_type[i] = T_PRESS;
      case (st[i])
        IDLE: begin
          if (rise[i]) begin
            emit[i]    = 1'b1;
            cnt_nxt[i] = '0;
            st_nxt[i]  = HELD;
          end
        end
        HELD, RPT: begin
          if (fall[i]) begin
            emit[i]      = 1'b1;
            emit_type[i] = T_RELEASE;
            st_nxt[i]    = IDLE;
          end else if (tick) begin
            if ((st[i] == HELD) && (cnt[i] == CW'(LONG_MS - 1))) begin
              emit[i]      = 1'b1;
              emit_type[i] = T_LONG;
              cnt_nxt[i]   = '0;
              st_nxt[i]    = RPT;
            end else if ((st[i] == RPT) && (cnt[i] == CW'(REPEAT_MS - 1))) begin
              emit[i]      = 1'b1;
              emit_type[i] = T_REPEAT;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        default: st_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pend_vld[idx]) begin
        found = 1'b1;
        win   = BW'(idx);
      end
    end
    if (free && found) grant[win] = 1'b1;
  end

  assign drop = emit & pend_vld & ~grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        st[i]        <= IDLE;
        cnt[i]       <= '0;
        pend_vld[i]  <= 1'b0;
        pend_type[i] <= T_PRESS;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
        if (emit[i]) begin
          pend_vld[i]  <= 1'b1;
          pend_type[i] <= emit_type[i];
        end else if (grant[i]) begin
          pend_vld[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_type  <= T_PRESS;
      evt_drop  <= 1'b0;
      rr        <= '0;
    end else begin
      evt_drop <= |drop;
      if (free) begin
        if (found) begin
          evt_valid <= 1'b1;
          evt_btn   <= win;
          evt_type  <= pend_type[win];
          rr        <= (win == BW'(N_BTN - 1)) ? '0 : win + 1'b1;
        end else begin
          evt_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl at 10 cycles/ms, LONG 5 ms, REPEAT 2 ms.
module tb_button_event_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic       evt_drop;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ndrop  = 0;
  int ev_b[$];
  int ev_t[$];
  int ev_c[$];

  button_event_ctrl #(.CLK_FREQ_HZ(10000), .N_BTN(4), .LONG_MS(5), .REPEAT_MS(2)) dut (
    .clk(clk), .rst(rst), .btn_level(btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_btn(evt_btn), .evt_type(evt_type), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      ev_b.push_back(int'(evt_btn));
      ev_t.push_back(int'(evt_type));
      ev_c.push_back(cyc);
    end
    if (!rst && evt_drop) ndrop++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    ev_b.delete();
    ev_t.delete();
    ev_c.delete();
    ndrop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  int c, f, n, d, nrep;
  logic hit;

  initial begin
    rst = 1'b0; btn = 4'b0; evt_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", evt_valid, 0);
    check("rst_btn", evt_btn, 0);
    check("rst_type", evt_type, 0);
    check("rst_drop", evt_drop, 0);
    step(3);
    rst = 1'b0;
    step(2);

    // 1: short press on btn 0
    clear_log();
    c = cyc; btn[0] = 1'b1;
    step(20);
    f = cyc; btn[0] = 1'b0;
    step(5);
    check("t1_count", ev_t.size(), 2);
    if (ev_t.size() >= 2) begin
      check("t1_press_b", ev_b[0], 0);
      check("t1_press_t", ev_t[0], 0);
      check("t1_press_c", ev_c[0], c + 2);
      check("t1_rel_t", ev_t[1], 1);
      check("t1_rel_c", ev_c[1], f + 2);
    end
    check("t1_drop", ndrop, 0);

    // 2: long hold on btn 1
    clear_log();
    c = cyc; btn[1] = 1'b1;
    step(150);
    f = cyc; btn[1] = 1'b0;
    step(5);
    n = ev_t.size();
    nrep = n - 3;
    check("t2_nrep", (nrep >= 4 && nrep <= 5), 1);
    if (n >= 3) begin
      check("t2_press_t", ev_t[0], 0);
      check("t2_press_c", ev_c[0], c + 2);
      check("t2_long_t", ev_t[1], 2);
      d = ev_c[1] - ev_c[0];
      check("t2_long_dly", (d >= 40 && d <= 50), 1);
      for (int i = 2; i < n - 1; i++) begin
        check("t2_rep_t", ev_t[i], 3);
        check("t2_rep_b", ev_b[i], 1);
        check("t2_rep_gap", ev_c[i] - ev_c[i-1], 20);
      end
      check("t2_rel_t", ev_t[n-1], 1);
      check("t2_rel_c", ev_c[n-1], f + 2);
    end

    // 3: simultaneous rise on all four, rr starts from 0 after reset
    do_reset();
    clear_log();
    c = cyc; btn = 4'b1111;
    step(8);
    btn = 4'b0000;
    step(8);
    check("t3_count", ev_t.size(), 8);
    if (ev_t.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_press_b", ev_b[i], i);
        check("t3_press_t", ev_t[i], 0);
        check("t3_press_c", ev_c[i], c + 2 + i);
        check("t3_rel_b", ev_b[i+4], i);
        check("t3_rel_t", ev_t[i+4], 1);
      end
    end

    // 4: stall with PRESS/2 at the output, btn 3 pulses
    clear_log();
    evt_ready = 1'b0;
    btn[2] = 1'b1;
    step(2);
    btn[3] = 1'b1;
    step(1);
    btn[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t4_hold_v", evt_valid, 1);
      check("t4_hold_b", evt_btn, 2);
      check("t4_hold_t", evt_type, 0);
    end
    check("t4_drop", ndrop, 1);
    evt_ready = 1'b1;
    step(4);
    btn[2] = 1'b0;
    step(5);
    check("t4_count", ev_t.size(), 3);
    if (ev_t.size() == 3) begin
      check("t4_e0_b", ev_b[0], 2);
      check("t4_e0_t", ev_t[0], 0);
      check("t4_e1_b", ev_b[1], 3);
      check("t4_e1_t", ev_t[1], 1);
      check("t4_e2_b", ev_b[2], 2);
      check("t4_e2_t", ev_t[2], 1);
    end

    // 5: btn 0 and 1 held together, aligned ticks
    clear_log();
    btn[1:0] = 2'b11;
    step(100);
    btn[1:0] = 2'b00;
    step(5);
    n = ev_t.size();
    nrep = 0;
    for (int i = 0; i < n; i++) begin
      check("t5_alt_b", ev_b[i], i % 2);
      if (ev_t[i] == 3) nrep++;
    end
    check("t5_nrep", (nrep >= 4 && nrep % 2 == 0), 1);
    check("t5_drop", ndrop, 0);

    // 6: async reset while btn 0 repeats
    clear_log();
    btn[0] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 120 && !hit; i++) begin
      @(negedge clk);
      if (evt_valid && evt_type == 2'b11) hit = 1'b1;
    end
    check("t6_reach_rep", hit, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_type", evt_type, 0);
    step(3);
    btn[0] = 1'b0;
    rst = 1'b0;
    clear_log();
    step(60);
    check("t6_quiet", ev_t.size(), 0);
    c = cyc; btn[0] = 1'b1;
    step(4);
    check("t6_count", ev_t.size(), 1);
    if (ev_t.size() >= 1) begin
      check("t6_press_b", ev_b[0], 0);
      check("t6_press_t", ev_t[0], 0);
      check("t6_press_c", ev_c[0], c + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
